ldpc_frame_sched: RTL and testbench

Frame-level controller for the `ldpc_core` decoder in the BER test harness. Accepts complete quantized LLR frames from the noise/quantizer buffer bank and sequences each one through the decoder: reset, run, wait for `term` or timeout. It then counts bit errors in the decoded word against the all-zero transmitted codeword and repeats for a programmed number of frames. Sits between the `gng`/`quant` buffer bank and `ldpc_core`, and replaces ad-hoc sequencing in the top level.

---
 rtl/ldpc_pkg.sv | 35 +++
 rtl/ldpc_err_acc.sv | 52 +++++
 rtl/ldpc_frame_sched.sv | 155 +++++++++++++++
 tb/tb_ldpc_frame_sched.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared types, sizes and helpers for the LDPC frame scheduler.
// Holds the FSM state enum, codeword/LLR sizes, counter widths and SAT_ADD.
package ldpc_pkg;

    localparam int DIM    = 2304;
    localparam int DATA_W = 5;

    localparam int FRM_W = 16;
    localparam int EF_W  = 12;
    localparam int BE_W  = 24;
    localparam int TO_W  = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRST,
        S_RUN,
        S_CHECK,
        S_FIN
    } state_t;

    // Add and clamp to the largest value representable in w bits.
    function automatic logic [31:0] SAT_ADD(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          w
    );
        logic [32:0] s;
        logic [32:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = (33'd1 << w) - 33'd1;
        return (s > m) ? m[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/ldpc_err_acc.sv
// Bit-error accumulator: popcounts one result chunk per cycle into a frame sum.
// Ports: clr (run start), acc (chunk valid), commit (last chunk), chunk, frame_err, bit_errs.
module ldpc_err_acc
    import ldpc_pkg::*;
#(
    parameter int CHK_W  = 96,
    parameter int FSUM_W = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             acc,
    input  logic             commit,
    input  logic [CHK_W-1:0] chunk,
    output logic             frame_err,
    output logic [BE_W-1:0]  bit_errs
);
    localparam int PC_W = $clog2(CHK_W + 1);

    logic [PC_W-1:0]   pc;
    logic [FSUM_W-1:0] fsum;
    logic [FSUM_W-1:0] fsum_nxt;

    always_comb begin
        pc = '0;
        for (int i = 0; i < CHK_W; i++) begin
            pc = pc + PC_W'(chunk[i]);
        end
    end

    // Frame total including the chunk being accumulated this cycle.
    assign fsum_nxt  = fsum + FSUM_W'(pc);
    assign frame_err = (fsum_nxt != '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fsum     <= '0;
            bit_errs <= '0;
        end else if (clr) begin
            fsum     <= '0;
            bit_errs <= '0;
        end else if (acc) begin
            if (commit) begin
                fsum     <= '0;
                bit_errs <= BE_W'(SAT_ADD(32'(bit_errs), 32'(fsum_nxt), BE_W));
            end else begin
                fsum <= fsum_nxt;
            end
        end
    end

endmodule

// File: rtl/ldpc_frame_sched.sv
// Frame-level sequencer for ldpc_core: load, reset, run, check, repeat.
// Ports: start/num_frames, frm_* handshake, dec_* decoder side, busy/done and run counters.
module ldpc_frame_sched
    import ldpc_pkg::*;
#(
    parameter int CHK_W = 96,
    parameter int TMO_W = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [FRM_W-1:0]      num_frames,
    input  logic                  frm_valid,
    output logic                  frm_ready,
    input  logic [DIM*DATA_W-1:0] frm_llr,
    output logic                  dec_en,
    output logic                  dec_rst,
    output logic [DIM*DATA_W-1:0] dec_llr,
    input  logic                  dec_term,
    input  logic [DIM-1:0]        dec_res,
    output logic                  busy,
    output logic                  done,
    output logic [FRM_W-1:0]      frames_done,
    output logic [EF_W-1:0]       err_frames,
    output logic [BE_W-1:0]       bit_errs,
    output logic [TO_W-1:0]       timeouts
);
    localparam int NCHK   = DIM / CHK_W;
    localparam int CK_W   = (NCHK > 1) ? $clog2(NCHK) : 1;
    localparam int FSUM_W = $clog2(DIM + 1);
    localparam logic [CK_W-1:0] CK_LAST = CK_W'(NCHK - 1);
    // Last RUN cycle: the incremented count reaches all-ones here.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t state;
    state_t state_nxt;

    logic [FRM_W-1:0] nf_q;
    logic [TMO_W-1:0] run_cnt;
    logic [CK_W-1:0]  chk_idx;
    logic [DIM-1:0]   res_q;

    logic tmo_hit;
    logic frame_end;
    logic frame_err;
    logic acc_clr;
    logic acc_en;
    logic acc_commit;

    assign frm_ready = (state == S_LOAD);
    assign dec_en    = (state == S_RUN);
    assign dec_rst   = (state == S_IDLE) || (state == S_DRST) || (state == S_FIN);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FIN);

    always_comb begin
        state_nxt  = state;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        acc_commit = 1'b0;
        frame_end  = 1'b0;
        tmo_hit    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    acc_clr   = 1'b1;
                    state_nxt = (num_frames == '0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (frm_valid) state_nxt = S_DRST;
            end
            S_DRST: state_nxt = S_RUN;
            S_RUN: begin
                // A term in the final cycle is a normal finish.
                if (dec_term) begin
                    state_nxt = S_CHECK;
                end else if (run_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    frame_end = 1'b1;
                end
            end
            S_CHECK: begin
                acc_en = 1'b1;
                if (chk_idx == CK_LAST) begin
                    acc_commit = 1'b1;
                    frame_end  = 1'b1;
                end
            end
            S_FIN: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (frame_end) begin
            state_nxt = (frames_done + 1'b1 == nf_q) ? S_FIN : S_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            nf_q        <= '0;
            run_cnt     <= '0;
            chk_idx     <= '0;
            res_q       <= '0;
            dec_llr     <= '0;
            frames_done <= '0;
            err_frames  <= '0;
            timeouts    <= '0;
        end else begin
            if (acc_clr) begin
                nf_q        <= num_frames;
                frames_done <= '0;
                err_frames  <= '0;
                timeouts    <= '0;
            end
            if (state == S_LOAD && frm_valid) dec_llr <= frm_llr;
            if (state == S_DRST)     run_cnt <= '0;
            else if (state == S_RUN) run_cnt <= run_cnt + 1'b1;
            // Result is shifted down so chunk k is always in the low bits.
            if (state == S_RUN && dec_term) begin
                res_q   <= dec_res;
                chk_idx <= '0;
            end else if (state == S_CHECK) begin
                res_q   <= res_q >> CHK_W;
                chk_idx <= chk_idx + 1'b1;
            end
            if (frame_end) frames_done <= frames_done + 1'b1;
            if (tmo_hit) begin
                timeouts <= TO_W'(SAT_ADD(32'(timeouts), 32'd1, TO_W));
            end
            if (tmo_hit || (acc_commit && frame_err)) begin
                err_frames <= EF_W'(SAT_ADD(32'(err_frames), 32'd1, EF_W));
            end
        end
    end

    ldpc_err_acc #(
        .CHK_W  (CHK_W),
        .FSUM_W (FSUM_W)
    ) u_acc (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (acc_clr),
        .acc       (acc_en),
        .commit    (acc_commit),
        .chunk     (res_q[CHK_W-1:0]),
        .frame_err (frame_err),
        .bit_errs  (bit_errs)
    );

endmodule

// File: tb/tb_ldpc_frame_sched.sv
// Testbench for ldpc_frame_sched with a behavioural decoder and result scoreboard.
// Ports: none; drives the DUT and prints one summary line.
module tb_ldpc_frame_sched;
    import ldpc_pkg::*;

    typedef struct {
        int frames;
        int errf;
        int bits;
        int tmo;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  start = 1'b0;
    logic [FRM_W-1:0]      num_frames = '0;
    logic                  frm_valid = 1'b0;
    logic                  frm_ready;
    logic [DIM*DATA_W-1:0] frm_llr = '0;
    logic                  dec_en;
    logic                  dec_rst;
    logic [DIM*DATA_W-1:0] dec_llr;
    logic                  dec_term;
    logic [DIM-1:0]        dec_res;
    logic                  busy;
    logic                  done;
    logic [FRM_W-1:0]      frames_done;
    logic [EF_W-1:0]       err_frames;
    logic [BE_W-1:0]       bit_errs;
    logic [TO_W-1:0]       timeouts;

    int             term_at = 5;
    logic [DIM-1:0] res_pat = '0;
    int             run_cyc = 0;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    int   hs_q[$];
    int   done_at;
    int   done_cnt;
    int   en_cnt;
    int   early_chg;
    logic busy_post;
    int   s_frames;
    int   s_errf;
    int   s_bits;
    int   s_tmo;

    ldpc_frame_sched dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .num_frames  (num_frames),
        .frm_valid   (frm_valid),
        .frm_ready   (frm_ready),
        .frm_llr     (frm_llr),
        .dec_en      (dec_en),
        .dec_rst     (dec_rst),
        .dec_llr     (dec_llr),
        .dec_term    (dec_term),
        .dec_res     (dec_res),
        .busy        (busy),
        .done        (done),
        .frames_done (frames_done),
        .err_frames  (err_frames),
        .bit_errs    (bit_errs),
        .timeouts    (timeouts)
    );

    always #5 clk = ~clk;

    // Decoder model: term in RUN cycle number term_at (0 = never).
    always @(posedge clk) begin
        if (dec_rst)     run_cyc <= 0;
        else if (dec_en) run_cyc <= run_cyc + 1;
    end
    assign dec_term = dec_en && (term_at != 0) && (run_cyc == term_at - 1);
    assign dec_res  = res_pat;

    task automatic rand_llr();
        for (int i = 0; i < DIM * DATA_W; i += 32) frm_llr[i +: 32] = $urandom;
    endtask

    // Start a run and record what the DUT does until just after done.
    task automatic drive_run(input int nf, input int vdelay, input int budget);
        logic [DIM*DATA_W-1:0] llr0;
        bit fin;
        hs_q.delete();
        done_at = -1;
        done_cnt = 0;
        en_cnt = 0;
        early_chg = 0;
        busy_post = 1'b1;
        fin = 0;
        llr0 = dec_llr;
        @(posedge clk); #1;
        start = 1'b1;
        num_frames = FRM_W'(nf);
        frm_valid = (vdelay == 0);
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge clk);
            if (hs_q.size() == 0 && dec_llr !== llr0) early_chg++;
            if (frm_ready && frm_valid) hs_q.push_back(c);
            if (dec_en) en_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at  = c;
                    s_frames = int'(frames_done);
                    s_errf   = int'(err_frames);
                    s_bits   = int'(bit_errs);
                    s_tmo    = int'(timeouts);
                end
            end
            if (done_at >= 0 && c == done_at + 1) busy_post = busy;
            if (done_at >= 0 && c >= done_at + 2) fin = 1;
            @(posedge clk); #1;
            start = 1'b0;
            frm_valid = (c + 1 >= vdelay);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({frm_ready, dec_en, dec_rst, busy, done} !== 5'b00100) begin
            bad++;
            $display("FAIL rst_ctrl: got %b want 00100", {frm_ready, dec_en, dec_rst, busy, done});
        end
        total++;
        if ({frames_done, err_frames, bit_errs, timeouts} !== '0) begin
            bad++;
            $display("FAIL rst_cnt: got %0d/%0d/%0d/%0d want 0/0/0/0", frames_done, err_frames, bit_errs, timeouts);
        end
        total++;
        if (dec_llr !== '0) begin
            bad++;
            $display("FAIL rst_llr: got %h want 0", dec_llr[31:0]);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_multi();
        exp_t e;
        term_at = 5;
        res_pat = '0;
        rand_llr();
        sb.push_back('{3, 0, 0, 0});
        drive_run(3, 0, 300);
        e = sb.pop_front();
        total++;
        if (done_at < 0) begin
            bad++;
            $display("FAIL mf_done: got none want done");
        end else begin
            total++;
            if (s_frames !== e.frames) begin bad++; $display("FAIL mf_frames: got %0d want %0d", s_frames, e.frames); end
            total++;
            if (s_errf !== e.errf) begin bad++; $display("FAIL mf_errf: got %0d want %0d", s_errf, e.errf); end
            total++;
            if (s_bits !== e.bits) begin bad++; $display("FAIL mf_bits: got %0d want %0d", s_bits, e.bits); end
            total++;
            if (s_tmo !== e.tmo) begin bad++; $display("FAIL mf_tmo: got %0d want %0d", s_tmo, e.tmo); end
        end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL mf_pulses: got %0d want 1", done_cnt); end
        total++;
        if (en_cnt !== 15) begin bad++; $display("FAIL mf_en: got %0d want 15", en_cnt); end
        total++;
        if (busy_post !== 1'b0) begin bad++; $display("FAIL mf_busy: got %b want 0", busy_post); end
        total++;
        if (hs_q.size() !== 3) begin
            bad++;
            $display("FAIL mf_hs: got %0d want 3", hs_q.size());
        end else begin
            total++;
            if (hs_q[1] - hs_q[0] !== 31) begin bad++; $display("FAIL mf_per1: got %0d want 31", hs_q[1] - hs_q[0]); end
            total++;
            if (hs_q[2] - hs_q[1] !== 31) begin bad++; $display("FAIL mf_per2: got %0d want 31", hs_q[2] - hs_q[1]); end
            total++;
            if (done_at - hs_q[2] !== 31) begin bad++; $display("FAIL mf_per3: got %0d want 31", done_at - hs_q[2]); end
        end
        total++;
        if (dec_llr !== frm_llr) begin bad++; $display("FAIL mf_llr: got %h want %h", dec_llr[31:0], frm_llr[31:0]); end
    endtask

    task automatic test_bit_errs();
        exp_t e;
        term_at = 5;
        res_pat = '0;
        res_pat[0] = 1'b1;
        res_pat[95] = 1'b1;
        res_pat[96] = 1'b1;
        res_pat[DIM-1] = 1'b1;
        sb.push_back('{1, 1, 4, 0});
        drive_run(1, 0, 200);
        e = sb.pop_front();
        total++;
        if (done_at < 0) begin
            bad++;
            $display("FAIL be_done: got none want done");
        end else begin
            total++;
            if (s_frames !== e.frames) begin bad++; $display("FAIL be_frames: got %0d want %0d", s_frames, e.frames); end
            total++;
            if (s_errf !== e.errf) begin bad++; $display("FAIL be_errf: got %0d want %0d", s_errf, e.errf); end
            total++;
            if (s_bits !== e.bits) begin bad++; $display("FAIL be_bits: got %0d want %0d", s_bits, e.bits); end
            total++;
            if (s_tmo !== e.tmo) begin bad++; $display("FAIL be_tmo: got %0d want %0d", s_tmo, e.tmo); end
        end
        res_pat = '0;
    endtask

    task automatic test_zero_frames();
        exp_t e;
        sb.push_back('{0, 0, 0, 0});
        drive_run(0, 0, 20);
        e = sb.pop_front();
        total++;
        if (done_at !== 1) begin bad++; $display("FAIL zf_done_at: got %0d want 1", done_at); end
        total++;
        if (en_cnt !== 0) begin bad++; $display("FAIL zf_en: got %0d want 0", en_cnt); end
        total++;
        if (hs_q.size() !== 0) begin bad++; $display("FAIL zf_hs: got %0d want 0", hs_q.size()); end
        if (done_at >= 0) begin
            total++;
            if ({s_frames, s_errf, s_bits, s_tmo} !== {e.frames, e.errf, e.bits, e.tmo}) begin
                bad++;
                $display("FAIL zf_cnt: got %0d/%0d/%0d/%0d want 0/0/0/0", s_frames, s_errf, s_bits, s_tmo);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        term_at = 0;
        sb.push_back('{1, 1, 0, 1});
        drive_run(1, 0, 5000);
        e = sb.pop_front();
        total++;
        if (done_at < 0 || hs_q.size() != 1) begin
            bad++;
            $display("FAIL to_done: got done_at=%0d hs=%0d want done and 1 hs", done_at, hs_q.size());
        end else begin
            total++;
            if (done_at - hs_q[0] !== 4097) begin bad++; $display("FAIL to_lat: got %0d want 4097", done_at - hs_q[0]); end
            total++;
            if (s_tmo !== e.tmo) begin bad++; $display("FAIL to_tmo: got %0d want %0d", s_tmo, e.tmo); end
            total++;
            if (s_errf !== e.errf) begin bad++; $display("FAIL to_errf: got %0d want %0d", s_errf, e.errf); end
            total++;
            if (s_bits !== e.bits) begin bad++; $display("FAIL to_bits: got %0d want %0d", s_bits, e.bits); end
            total++;
            if (s_frames !== e.frames) begin bad++; $display("FAIL to_frames: got %0d want %0d", s_frames, e.frames); end
        end
        total++;
        if (en_cnt !== 4095) begin bad++; $display("FAIL to_en: got %0d want 4095", en_cnt); end
    endtask

    task automatic test_term_edge();
        exp_t e;
        term_at = 4095;
        sb.push_back('{1, 0, 0, 0});
        drive_run(1, 0, 5000);
        e = sb.pop_front();
        total++;
        if (done_at < 0 || hs_q.size() != 1) begin
            bad++;
            $display("FAIL te_done: got done_at=%0d hs=%0d want done and 1 hs", done_at, hs_q.size());
        end else begin
            total++;
            if (done_at - hs_q[0] !== 4121) begin bad++; $display("FAIL te_lat: got %0d want 4121", done_at - hs_q[0]); end
            total++;
            if (s_tmo !== e.tmo) begin bad++; $display("FAIL te_tmo: got %0d want %0d", s_tmo, e.tmo); end
            total++;
            if (s_errf !== e.errf) begin bad++; $display("FAIL te_errf: got %0d want %0d", s_errf, e.errf); end
        end
        total++;
        if (en_cnt !== 4095) begin bad++; $display("FAIL te_en: got %0d want 4095", en_cnt); end
        term_at = 5;
    endtask

    task automatic test_delayed_valid();
        exp_t e;
        term_at = 5;
        rand_llr();
        sb.push_back('{1, 0, 0, 0});
        drive_run(1, 50, 300);
        e = sb.pop_front();
        total++;
        if (early_chg !== 0) begin bad++; $display("FAIL dv_early: got %0d want 0", early_chg); end
        total++;
        if (hs_q.size() != 1) begin
            bad++;
            $display("FAIL dv_hs: got %0d want 1", hs_q.size());
        end else begin
            total++;
            if (hs_q[0] !== 50) begin bad++; $display("FAIL dv_hs_at: got %0d want 50", hs_q[0]); end
        end
        total++;
        if (dec_llr !== frm_llr) begin bad++; $display("FAIL dv_llr: got %h want %h", dec_llr[31:0], frm_llr[31:0]); end
        total++;
        if (s_frames !== e.frames) begin bad++; $display("FAIL dv_frames: got %0d want %0d", s_frames, e.frames); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int hs;
        int h2;
        bit hit;
        term_at = 5;
        res_pat = '0;
        hs = 0;
        h2 = -100;
        hit = 0;
        @(posedge clk); #1;
        start = 1'b1;
        num_frames = 16'd4;
        frm_valid = 1'b1;
        for (int c = 0; c < 400 && !hit; c++) begin
            @(negedge clk);
            if (frm_ready && frm_valid) begin
                hs++;
                if (hs == 2) h2 = c;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (c == h2 + 15) begin
                rstn = 1'b0;
                hit = 1;
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL rm_reach: got hs=%0d want 2", hs);
        end
        @(negedge clk);
        total++;
        if ({busy, dec_en, frm_ready, frames_done} !== {3'b100, 16'd1}) begin
            bad++;
            $display("FAIL rm_in_check: got busy=%b en=%b rdy=%b frames=%0d want 1/0/0/1", busy, dec_en, frm_ready, frames_done);
        end
        @(negedge clk);
        total++;
        if ({frm_ready, dec_en, dec_rst, busy, done} !== 5'b00100) begin
            bad++;
            $display("FAIL rm_ctrl: got %b want 00100", {frm_ready, dec_en, dec_rst, busy, done});
        end
        total++;
        if ({frames_done, err_frames, bit_errs, timeouts} !== '0 || dec_llr !== '0) begin
            bad++;
            $display("FAIL rm_cnt: got %0d/%0d/%0d/%0d llr=%h want 0/0/0/0 llr=0", frames_done, err_frames, bit_errs, timeouts, dec_llr[31:0]);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        sb.push_back('{4, 0, 0, 0});
        drive_run(4, 0, 400);
        e = sb.pop_front();
        total++;
        if (done_at < 0) begin
            bad++;
            $display("FAIL rm_done: got none want done");
        end else begin
            total++;
            if (s_frames !== e.frames) begin bad++; $display("FAIL rm_frames: got %0d want %0d", s_frames, e.frames); end
            total++;
            if (s_errf !== e.errf) begin bad++; $display("FAIL rm_errf: got %0d want %0d", s_errf, e.errf); end
        end
        total++;
        if (hs_q.size() !== 4) begin bad++; $display("FAIL rm_hs: got %0d want 4", hs_q.size()); end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL rm_pulses: got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_multi();
        test_bit_errs();
        test_zero_frames();
        test_timeout();
        test_term_edge();
        test_delayed_valid();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
